// File: rtl/ternary_secret_packer.sv
// Packs ternary secret coefficients (2 bits each, 8 per word) into the operand RAM, then runs the multiplier.
// Latency: word write 1 cycle after its 8th accept; mul_start 2 cycles after the last accept; done 1 cycle after mul_done.
// Backpressure: in_ready is high only in IDLE/COLLECT. SECRET_PACK_SATURATE_EN saturates out-of-range inputs by sign.
module ternary_secret_packer #(
    parameter int         N          = 256,
    parameter int         COEFF_IN_W = 4,
    parameter logic [8:0] BASE_ADDR  = 9'h100
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COEFF_IN_W-1:0] in_coeff,
    output logic                  mem_we,
    output logic [8:0]            mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mul_start,
    input  logic                  mul_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = $clog2(N);
    localparam logic signed [COEFF_IN_W-1:0] C_ZERO = COEFF_IN_W'(0);
    localparam logic signed [COEFF_IN_W-1:0] C_POS1 = COEFF_IN_W'(1);
    localparam logic signed [COEFF_IN_W-1:0] C_NEG1 = COEFF_IN_W'(-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_LAUNCH,
        S_WAIT,
        S_FIN
    } state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [15:0]             pack;
    logic [15:0]             word_nxt;
    logic [1:0]              code;
    logic                    coeff_bad;
    logic                    accept;
    logic                    last;
    logic [2:0]              lane;
    logic signed [COEFF_IN_W-1:0] c_s;

    assign c_s    = $signed(in_coeff);
    assign accept = in_valid & in_ready;
    assign last   = (idx == IDX_W'(N - 1));
    assign lane   = idx[2:0];

    // Encoding: bit0 = nonzero enable, bit1 = negate.
    always_comb begin
        code      = 2'b00;
        coeff_bad = 1'b0;
        if (c_s == C_ZERO) begin
            code = 2'b00;
        end else if (c_s == C_POS1) begin
            code = 2'b01;
        end else if (c_s == C_NEG1) begin
            code = 2'b11;
        end else begin
            coeff_bad = 1'b1;
`ifdef SECRET_PACK_SATURATE_EN
            code = (c_s > C_POS1) ? 2'b01 : 2'b11;
`else
            code = 2'b00;
`endif
        end
    end

    always_comb begin
        word_nxt                  = pack;
        word_nxt[{lane, 1'b0} +: 2] = code;
    end

    assign in_ready  = (state == S_IDLE) || (state == S_COLLECT);
    assign busy      = (state != S_IDLE);
    assign mul_start = (state == S_LAUNCH);
    assign done      = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_COLLECT;
            S_COLLECT: if (accept && last) state_nxt = S_FLUSH;
            S_FLUSH:   state_nxt = S_LAUNCH;
            S_LAUNCH:  state_nxt = S_WAIT;
            S_WAIT:    if (mul_done) state_nxt = S_FIN;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx       <= '0;
            pack      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                idx <= last ? '0 : idx + 1'b1;
                // A new frame starts with a clean error flag.
                err <= (state == S_IDLE) ? coeff_bad : (err | coeff_bad);
                if (lane == 3'd7) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= BASE_ADDR + 9'(idx >> 3);
                    mem_wdata <= word_nxt;
                    pack      <= '0;
                end else begin
                    pack <= word_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ternary_secret_packer.sv
// Randomized scoreboard bench for ternary_secret_packer: driver pushes expected writes/pulses, negedge monitor pops and compares.
module tb_ternary_secret_packer;

    localparam int N    = 256;
    localparam int BASE = 'h100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_coeff = '0;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    ternary_secret_packer #(.N(N), .COEFF_IN_W(4), .BASE_ADDR(9'h100)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_coeff(in_coeff), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mul_start(mul_start), .mul_done(mul_done),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  sq[$];
    int  dq[$];
    int  total = 0;
    int  bad = 0;
    int  coeffs[N];
    wr_t mon_e;
    int  mon_c;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int ref_code(int c);
        if (c == 0)  return 0;
        if (c == 1)  return 1;
        if (c == -1) return 3;
`ifdef SECRET_PACK_SATURATE_EN
        return (c > 1) ? 1 : 3;
`else
        return 0;
`endif
    endfunction

    function automatic bit ref_bad(int c);
        return (c < -1) || (c > 1);
    endfunction

    // Monitor: every observed write / start / done must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (wq.size() == 0) chk("spurious_write", 1, 0);
                else begin
                    mon_e = wq.pop_front();
                    chk("wr_addr", int'(mem_addr), mon_e.addr);
                    chk("wr_data", int'(mem_wdata), mon_e.data);
                    chk("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (mul_start) begin
                if (sq.size() == 0) chk("spurious_mul_start", 1, 0);
                else begin
                    mon_c = sq.pop_front();
                    chk("mul_start_cycle", cyc, mon_c);
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    mon_c = dq.pop_front();
                    chk("done_cycle", cyc, mon_c);
                end
            end
        end
    end

    // mode: 0 all +1, 1 fixed pattern, 2 coeff5=3 else 0, 3 random (mostly in range)
    task automatic run_frame(input int mode, input bit gaps, input bit stray_done, input int abort_at);
        int  pat[8] = '{1, -1, 0, 1, -1, 0, 1, -1};
        int  i, d, w, guard, tmp;
        bit  frame_err, stray_sent, err_checked, v;
        wr_t e;
        frame_err = 0;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       coeffs[k] = 1;
                1:       coeffs[k] = pat[k % 8];
                2:       coeffs[k] = (k == 5) ? 3 : 0;
                default: coeffs[k] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) - 1
                                                                : int'($urandom_range(0, 15)) - 8;
            endcase
            if (k < abort_at && ref_bad(coeffs[k])) frame_err = 1;
        end
        i = 0; d = 0; guard = 0;
        stray_sent = 0; err_checked = 0;
        while (i < N && i < abort_at) begin
            @(negedge clk);
            if (i == 1 && !err_checked) begin
                chk("err_first_accept", int'(err), int'(ref_bad(coeffs[0])));
                err_checked = 1;
            end
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            tmp = coeffs[i];
            in_valid = v;
            in_coeff = tmp[3:0];
            mul_done = 1'b0;
            if (stray_done && i == 40 && !stray_sent) begin
                mul_done = 1'b1;
                stray_sent = 1;
            end
            if (v && in_ready) begin
                d = cyc;
                guard = 0;
                if (i % 8 == 7) begin
                    w = 0;
                    for (int j = 0; j < 8; j++) w += ref_code(coeffs[i - 7 + j]) * (1 << (2 * j));
                    e.addr = (BASE + i / 8) % 512;
                    e.data = w;
                    e.cyc  = d + 1;
                    wq.push_back(e);
                end
                i++;
            end else begin
                guard++;
                if (guard > 50) begin
                    chk("in_ready_timeout", int'(in_ready), 1);
                    break;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        mul_done = 1'b0;
        if (abort_at < N) begin
            resetn = 1'b0;
            @(negedge clk);
            chk("abort_mem_we", int'(mem_we), 0);
            chk("abort_mul_start", int'(mul_start), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            chk("abort_err", int'(err), 0);
            resetn = 1'b1;
            repeat (5) @(negedge clk);
            return;
        end
        chk("in_ready_after_last", int'(in_ready), 0);
        sq.push_back(d + 2);
        repeat (10) @(negedge clk);
        chk("busy_in_wait", int'(busy), 1);
        mul_done = 1'b1;
        dq.push_back(cyc + 1);
        @(negedge clk);
        mul_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_after_done", int'(err), int'(frame_err));
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_mul_start", int'(mul_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        resetn = 1'b1;
        @(negedge clk);

        run_frame(0, 0, 0, N);
        run_frame(1, 0, 0, N);
        run_frame(2, 0, 0, N);
        run_frame(3, 1, 1, N);
        run_frame(3, 0, 0, 100);
        run_frame(3, 1, 0, N);

        for (int t = 0; t < 100 && (wq.size() + sq.size() + dq.size()) != 0; t++) @(negedge clk);
        chk("pending_writes", wq.size(), 0);
        chk("pending_starts", sq.size(), 0);
        chk("pending_dones", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
